qam_mapper: RTL and testbench
=============================

# qam_mapper

Sequential serial-bit-to-symbol mapper: the parametrised successor of the fixed two-bit QPSK mapper in the baseband transmit chain. Collects 1, 2 or 4 serial bits per symbol according to a run-time mode (BPSK / QPSK / 16-QAM). Maps each group to a Gray-coded constellation point in Q16 signed fixed point. Presents the point behind a valid/ready output register to the downstream pulse-shaping / IFFT stage.

## Interface
- `DW`, 32, output sample width in bits; legal range ≥ 18. Values are sign-extended to DW.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `mode`  in  2  0 = BPSK, 1 = QPSK, 2 = 16-QAM, 3 = reserved (treated as QPSK).
- `bit_in`  in  1  serial data bit.
- `bit_valid`  in  1  `bit_in` is valid this cycle.
- `bit_ready`  out  1  mapper accepts `bit_in` this cycle.
- `flush`  in  1  synchronous; discard the partially collected symbol.
- `re`  out  DW  in-phase sample, signed Q16.
- `im`  out  DW  quadrature sample, signed Q16.
- `sym_valid`  out  1  `re`/`im` hold an unconsumed symbol.
- `sym_ready`  in  1  downstream accepts the symbol.

## Operation
- Bits per symbol: N = 1 (BPSK), 2 (QPSK/reserved), 4 (16-QAM).
- Bit transfer: occurs when `bit_valid && bit_ready`.
  - The first accepted bit of a symbol is b0, then b1, and so on.
  - Bits are held in a 4-bit shift register with a 2-bit count `cnt`.
- Mode latching: `mode` is captured when the first bit of a symbol is accepted (`cnt == 0`). Changes to `mode` mid-symbol have no effect until the next symbol.
- Mapping, where the sign bit maps 0 → positive and 1 → negative:
  - BPSK: re = ±65536 by b0; im = 0.
  - QPSK: re = ±46341 by b0; im = ±46341 by b1.
  - 16-QAM: re sign by b0, im sign by b1. Magnitude by b2 (re) and b3 (im): 0 → 20724, 1 → 62173. Per axis this is Gray order +3, +1, −1, −3.
- Symbol completion: when the N-th bit is accepted, the mapped point is written into the output register, `sym_valid` sets, and `cnt` returns to 0.
- Symbol consumption: occurs when `sym_valid && sym_ready`. `sym_valid` clears unless a new symbol completes in the same cycle. In that case the register reloads and `sym_valid` stays 1.
- Backpressure:
  - `bit_ready = !flush && (cnt != N-1 || !sym_valid || sym_ready)`.
  - Non-final bits are always accepted. Only the final bit stalls on a full, unconsumed output register.
- `flush`:
  - Clears `cnt` and the shift register.
  - Does not touch `re`/`im`/`sym_valid`.
  - Forces `bit_ready` low, so a bit presented in the same cycle is not taken.
- `re`/`im` remain stable while `sym_valid && !sym_ready`.

## Timing
- Reset values: `re` = 0, `im` = 0, `sym_valid` = 0, `bit_ready` = 1, `cnt` = 0, latched mode = QPSK.
- Latency: `sym_valid` rises on the clock edge that accepts the final bit. The symbol is visible the following cycle (1-cycle latency from the last bit).
- Throughput: one bit per cycle sustained when `sym_ready` is held high. BPSK yields one symbol per cycle, with no bubbles.
- Reset asserted mid-symbol or with a pending output: everything returns to reset values immediately (asynchronously). Partial bits are lost.

## Configuration
- `QAM_MAPPER_16QAM_EN`
  - Defined: mode 2 operates as 16-QAM as above.
  - Undefined:
    - The 16-QAM magnitude logic and the upper two shift-register bits are removed.
    - Mode 2 behaves exactly as mode 1 (QPSK, N = 2).
    - All other behaviour is unchanged.

## Test plan
- Reset, then QPSK with bits 0,0 / 1,0 / 0,1 / 1,1 and `sym_ready`=1 → four symbols (+46341,+46341), (−46341,+46341), (+46341,−46341), (−46341,−46341), each one cycle after its second bit.
- BPSK with a continuous bit stream 0,1,1,0 → `sym_valid` high four consecutive cycles with re = +65536, −65536, −65536, +65536 and im = 0.
- 16-QAM with bits b0..b3 = 0,1,1,0 → re = +62173, im = −20724. With 1,1,1,1 → (−62173, −62173). With the macro undefined, the same stream gives two QPSK symbols.
- Backpressure: `sym_ready`=0 with a pending symbol. `bit_ready` stays 1 for non-final bits and drops to 0 at the final bit; `re`/`im` are unchanged. Raising `sym_ready` completes the new symbol in the same cycle, with no loss or duplication.
- Change `mode` from 2 to 0 after b1 of a 16-QAM symbol → the symbol still completes as 16-QAM after 4 bits, and the next symbol is BPSK.
- `flush` after two 16-QAM bits, then 4 new bits → a single symbol mapped from the new bits only. Asserting `rst_n`=0 mid-symbol clears `sym_valid` and `re`/`im` to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/qam_mapper.sv
// Serial-bit to Gray-coded BPSK/QPSK/16-QAM symbol mapper, Q16 outputs.
// Define QAM_MAPPER_16QAM_EN to enable 16-QAM; otherwise mode 2 maps as QPSK.
module qam_mapper #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic          bit_ready,
  input  logic          flush,
  output logic [DW-1:0] re,
  output logic [DW-1:0] im,
  output logic          sym_valid,
  input  logic          sym_ready
);

`ifdef QAM_MAPPER_16QAM_EN
  localparam int SW = 4;
`else
  localparam int SW = 2;
`endif
  localparam int IW = $clog2(SW);

  localparam logic [DW-1:0] K_BPSK = DW'(65536);
  localparam logic [DW-1:0] K_QPSK = DW'(46341);
`ifdef QAM_MAPPER_16QAM_EN
  localparam logic [DW-1:0] K_IN   = DW'(20724);
  localparam logic [DW-1:0] K_OUT  = DW'(62173);
`endif

  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    mode_use, nm1;
  logic [SW-1:0] sh_q, sh_d, bits;
  logic [DW-1:0] re_q, re_d, im_q, im_d;
  logic          sv_q, sv_d;
  logic          last, accept, done;

  function automatic logic [DW-1:0] sgn(
    input logic s,
    input logic [DW-1:0] m
  );
    return s ? -m : m;
  endfunction

  // Mode is sampled live on the first bit, then held for the symbol.
  assign mode_use = (cnt_q == 2'd0) ? mode : mode_q;

  always_comb begin
    nm1 = 2'd1;
    unique case (1'b1)
      (mode_use == 2'd0): nm1 = 2'd0;
`ifdef QAM_MAPPER_16QAM_EN
      (mode_use == 2'd2): nm1 = 2'd3;
`endif
      default: nm1 = 2'd1;
    endcase
  end

  assign last      = (cnt_q == nm1);
  assign bit_ready = !flush && (!last || !sv_q || sym_ready);
  assign accept    = bit_valid && bit_ready;
  assign done      = accept && last;

  always_comb begin
    bits = sh_q;
    bits[cnt_q[IW-1:0]] = bit_in;
  end

  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    mode_d = mode_q;
    if (flush) begin
      cnt_d = 2'd0;
      sh_d  = '0;
    end else if (accept) begin
      if (cnt_q == 2'd0) mode_d = mode;
      if (done) begin
        cnt_d = 2'd0;
        sh_d  = '0;
      end else begin
        cnt_d = cnt_q + 2'd1;
        sh_d  = bits;
      end
    end
  end

  always_comb begin
    re_d = re_q;
    im_d = im_q;
    if (done) begin
      unique case (1'b1)
        (nm1 == 2'd0): begin
          re_d = sgn(bits[0], K_BPSK);
          im_d = '0;
        end
`ifdef QAM_MAPPER_16QAM_EN
        (nm1 == 2'd3): begin
          re_d = sgn(bits[0], bits[2] ? K_OUT : K_IN);
          im_d = sgn(bits[1], bits[3] ? K_OUT : K_IN);
        end
`endif
        default: begin
          re_d = sgn(bits[0], K_QPSK);
          im_d = sgn(bits[1], K_QPSK);
        end
      endcase
    end
  end

  // A completing symbol may overwrite the one being consumed this cycle.
  assign sv_d = done || (sv_q && !sym_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      sh_q   <= '0;
      mode_q <= 2'd1;
      re_q   <= '0;
      im_q   <= '0;
      sv_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      mode_q <= mode_d;
      re_q   <= re_d;
      im_q   <= im_d;
      sv_q   <= sv_d;
    end
  end

  assign re        = re_q;
  assign im        = im_q;
  assign sym_valid = sv_q;

endmodule

// File: tb/tb_qam_mapper.sv
// Directed bench for qam_mapper: vector table plus corner-case sequences.
// Honours QAM_MAPPER_16QAM_EN for 16-QAM expectations.
module tb_qam_mapper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        bit_in, bit_valid, flush, sym_ready;
  logic        bit_ready, sym_valid;
  logic [31:0] re, im;

  int checks = 0;
  int fails  = 0;

  qam_mapper #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .flush(flush),
    .re(re), .im(im), .sym_valid(sym_valid),
    .sym_ready(sym_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] m;
    logic       b, v, f, r;
    logic       br, sv;
    int         re, im;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic [1:0] m, logic b, logic v, logic f, logic r,
    logic br, logic sv, int xr, int xi
  );
    vec_t t;
    t.m = m; t.b = b; t.v = v; t.f = f; t.r = r;
    t.br = br; t.sv = sv; t.re = xr; t.im = xi;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d",
               nm, $signed(act), $signed(exp));
    end
  endtask

  task automatic step(input logic [1:0] m, input logic b, input logic v,
                      input logic f, input logic r, output logic br);
    mode = m; bit_in = b; bit_valid = v; flush = f; sym_ready = r;
    #2;
    br = bit_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic b, input logic r);
    logic br;
    step(m, b, 1'b1, 1'b0, r, br);
  endtask

  task automatic idle();
    logic br;
    step(2'd1, 1'b0, 1'b0, 1'b0, 1'b1, br);
  endtask

  task automatic chk_sym(input string nm, input int xr, input int xi);
    chk({nm, "_sv"}, 32'(sym_valid), 32'd1);
    chk({nm, "_re"}, re, xr);
    chk({nm, "_im"}, im, xi);
  endtask

  task automatic chk_nosym(input string nm);
    chk({nm, "_sv"}, 32'(sym_valid), 32'd0);
  endtask

  localparam int Q = 46341;
  localparam int B = 65536;
  localparam int A1 = 20724;
  localparam int A3 = 62173;

  initial begin
    logic br;
    rst_n = 1'b0; mode = 2'd1; bit_in = 1'b0;
    bit_valid = 1'b0; flush = 1'b0; sym_ready = 1'b0;
    #3;
    chk("rst_re", re, 0);
    chk("rst_im", im, 0);
    chk("rst_sv", 32'(sym_valid), 0);
    chk("rst_br", 32'(bit_ready), 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 1, 1, Q, Q));
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 1, 1, -Q, Q));
    tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 1, Q, -Q));
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 1, -Q, -Q));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, B, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 1, -B, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 1, -B, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, B, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].m, tbl[i].b, tbl[i].v, tbl[i].f, tbl[i].r, br);
      chk($sformatf("tbl%0d_br", i), 32'(br), 32'(tbl[i].br));
      chk($sformatf("tbl%0d_sv", i), 32'(sym_valid), 32'(tbl[i].sv));
      if (tbl[i].sv) begin
        chk($sformatf("tbl%0d_re", i), re, tbl[i].re);
        chk($sformatf("tbl%0d_im", i), im, tbl[i].im);
      end
    end

`ifdef QAM_MAPPER_16QAM_EN
    send(2, 0, 1); chk_nosym("q16a1");
    send(2, 1, 1); chk_nosym("q16a2");
    send(2, 1, 1); chk_nosym("q16a3");
    send(2, 0, 1); chk_sym("q16a", A3, -A1);
    send(2, 1, 1); chk_nosym("q16b1");
    send(2, 1, 1); send(2, 1, 1);
    send(2, 1, 1); chk_sym("q16b", -A3, -A3);
`else
    send(2, 0, 1); chk_nosym("q16a1");
    send(2, 1, 1); chk_sym("q16a_s0", Q, -Q);
    send(2, 1, 1); chk_nosym("q16a3");
    send(2, 0, 1); chk_sym("q16a_s1", -Q, Q);
    send(2, 1, 1); send(2, 1, 1);
    chk_sym("q16b_s0", -Q, -Q);
    send(2, 1, 1); chk_nosym("q16b3");
    send(2, 1, 1); chk_sym("q16b_s1", -Q, -Q);
`endif
    idle();

    send(1, 0, 0); chk_nosym("bp1");
    send(1, 0, 0); chk_sym("bp_pend", Q, Q);
    step(1, 1, 1, 0, 0, br);
    chk("bp_br_nonfinal", 32'(br), 1);
    chk_sym("bp_hold1", Q, Q);
    step(1, 1, 1, 0, 0, br);
    chk("bp_br_final", 32'(br), 0);
    chk_sym("bp_hold2", Q, Q);
    step(1, 1, 1, 0, 1, br);
    chk("bp_br_release", 32'(br), 1);
    chk_sym("bp_new", -Q, -Q);
    idle(); chk_nosym("bp_drain");

    send(1, 1, 1); chk_nosym("ml1");
    send(0, 1, 1); chk_sym("ml_qpsk", -Q, -Q);
    send(0, 0, 1); chk_sym("ml_bpsk", B, 0);
    idle();
`ifdef QAM_MAPPER_16QAM_EN
    send(2, 1, 1); send(2, 0, 1);
    send(0, 0, 1); chk_nosym("ml16_3");
    send(0, 1, 1); chk_sym("ml16", -A1, A3);
    send(0, 1, 1); chk_sym("ml16_next", -B, 0);
    idle();
`endif

`ifdef QAM_MAPPER_16QAM_EN
    send(2, 1, 1); send(2, 1, 1);
    step(2, 1, 1, 1, 1, br);
    chk("fl_br", 32'(br), 0);
    send(2, 0, 1); chk_nosym("fl1");
    send(2, 1, 1); chk_nosym("fl2");
    send(2, 1, 1); chk_nosym("fl3");
    send(2, 0, 1); chk_sym("fl", A3, -A1);
`else
    send(1, 1, 1);
    step(1, 1, 1, 1, 1, br);
    chk("fl_br", 32'(br), 0);
    send(1, 0, 1); chk_nosym("fl1");
    send(1, 1, 1); chk_sym("fl", Q, -Q);
`endif
    idle();
    send(1, 0, 0); send(1, 1, 0);
    step(1, 0, 0, 1, 0, br);
    chk_sym("fl_keep", Q, -Q);
    idle(); chk_nosym("fl_keep_drain");

    send(1, 0, 0); send(1, 0, 0);
    chk_sym("ar_pend", Q, Q);
    send(1, 1, 0);
    bit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_sv", 32'(sym_valid), 0);
    chk("ar_re", re, 0);
    chk("ar_im", im, 0);
    chk("ar_br", 32'(bit_ready), 1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1, 1, 1); chk_nosym("ar_lost");
    send(1, 1, 1); chk_sym("ar_after", -Q, -Q);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
